// File: rtl/kw_sum_serial.sv
// kw_sum_serial
//   Serial vector summer. Operands arrive one per beat on a valid/ready
//   input stream and are accumulated; each completed frame produces one
//   registered {sum, count} result on a valid/ready output stream.
//
//   Handshake: a transfer happens on a rising clock edge where valid and
//   ready are both high. Producers hold data stable while valid && !ready.
//   The result stays stable while out_valid && !out_ready.
//
// Ports
//   clock      : rising-edge clock for all state
//   reset_n    : asynchronous active-low reset
//   in_valid   : operand beat offered
//   in_ready   : beat accepted when in_valid && in_ready
//   in_data    : operand value
//   in_last    : final beat of a short frame (ignored on beat NUM_INPUTS)
//   out_valid  : out_sum/out_count hold a completed frame
//   out_ready  : consumer accepts when out_valid && out_ready
//   out_sum    : frame sum modulo 2^DATA_WIDTH
//   out_count  : number of beats in the frame (1..NUM_INPUTS)
//   dbg_phase  : current frame phase (0 = FIRST, 1 = ACCUM)
module kw_sum_serial #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 4,
    parameter int CNT_WIDTH  = $clog2(NUM_INPUTS + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  dbg_phase
);

    typedef enum logic {
        PH_FIRST = 1'b0,
        PH_ACCUM = 1'b1
    } phase_t;

    localparam logic [CNT_WIDTH-1:0] LP_MAX_CNT = CNT_WIDTH'(NUM_INPUTS);
    localparam logic [CNT_WIDTH-1:0] LP_ONE     = CNT_WIDTH'(1);

    phase_t                  r_phase;
    logic [DATA_WIDTH-1:0]   r_acc;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_sum;
    logic [CNT_WIDTH-1:0]    r_out_count;

    phase_t                  w_phase_d;
    logic [DATA_WIDTH-1:0]   w_acc_d;
    logic [CNT_WIDTH-1:0]    w_cnt_d;
    logic                    w_out_valid_d;
    logic [DATA_WIDTH-1:0]   w_out_sum_d;
    logic [CNT_WIDTH-1:0]    w_out_count_d;

    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_acc_next;
    logic [CNT_WIDTH-1:0]    w_cnt_next;
    logic                    w_frame_end;

    // Any unconsumed result stalls every input beat, so readiness never
    // depends on the phase or on in_valid.
    assign in_ready  = reset_n && !(r_out_valid && !out_ready);
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign dbg_phase = r_phase;

    always_comb begin
        // The first beat of a frame loads the accumulator directly, which
        // removes the need for a clear cycle between frames.
        w_acc_next  = (r_phase == PH_FIRST) ? in_data : (r_acc + in_data);
        w_cnt_next  = (r_phase == PH_FIRST) ? LP_ONE  : (r_cnt + LP_ONE);
        w_frame_end = in_last || (w_cnt_next == LP_MAX_CNT);

        w_phase_d     = r_phase;
        w_acc_d       = r_acc;
        w_cnt_d       = r_cnt;
        w_out_valid_d = r_out_valid;
        w_out_sum_d   = r_out_sum;
        w_out_count_d = r_out_count;

        if (r_out_valid && out_ready) begin
            w_out_valid_d = 1'b0;
        end

        if (w_accept) begin
            w_acc_d = w_acc_next;
            w_cnt_d = w_cnt_next;
            if (w_frame_end) begin
                // A completing frame overrides the drain above so a result
                // can be consumed and replaced in the same cycle.
                w_phase_d     = PH_FIRST;
                w_out_valid_d = 1'b1;
                w_out_sum_d   = w_acc_next;
                w_out_count_d = w_cnt_next;
            end else begin
                w_phase_d = PH_ACCUM;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase     <= PH_FIRST;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
        end else begin
            r_phase     <= w_phase_d;
            r_acc       <= w_acc_d;
            r_cnt       <= w_cnt_d;
            r_out_valid <= w_out_valid_d;
            r_out_sum   <= w_out_sum_d;
            r_out_count <= w_out_count_d;
        end
    end

endmodule

// File: tb/tb_kw_sum_serial.sv
module tb_kw_sum_serial;

    logic       clock;
    logic       reset_n;

    // Instance with NUM_INPUTS = 4
    logic       in_valid, in_last, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, dbg_phase;
    logic [7:0] out_sum;
    logic [2:0] out_count;

    // Instance with NUM_INPUTS = 1
    logic       in_valid1, in_last1, out_ready1;
    logic [7:0] in_data1;
    logic       in_ready1, out_valid1, dbg_phase1;
    logic [7:0] out_sum1;
    logic [0:0] out_count1;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: beats of the frame in progress, expected results.
    logic [7:0]  beats_q[$];
    logic [10:0] exp_q[$];    // {count[2:0], sum[7:0]}
    logic [8:0]  exp_q1[$];   // {count[0:0], sum[7:0]}

    bit rand_ready = 0;

    kw_sum_serial #(.DATA_WIDTH(8), .NUM_INPUTS(4)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .dbg_phase(dbg_phase)
    );

    kw_sum_serial #(.DATA_WIDTH(8), .NUM_INPUTS(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
        .out_count(out_count1), .dbg_phase(dbg_phase1)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: a frame ends on in_last or on its 4th beat; the
    // result is the plain sum of its beats modulo 256 and the beat count.
    function automatic void model_beat(input logic [7:0] d, input logic l);
        int s;
        beats_q.push_back(d);
        if (l || beats_q.size() == 4) begin
            s = 0;
            foreach (beats_q[i]) s += int'(beats_q[i]);
            exp_q.push_back({3'(beats_q.size()), 8'(s % 256)});
            beats_q.delete();
        end
    endfunction

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic send0(input logic [7:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clock);
        while (!in_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 1);
        @(posedge clock);
        if (in_ready) model_beat(d, l);
        #1;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d);
        int t = 0;
        in_valid1 = 1'b1; in_data1 = d; in_last1 = $urandom_range(0, 1);
        @(negedge clock);
        while (!in_ready1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready1) chk("accept1_timeout", 32'(in_ready1), 1);
        @(posedge clock);
        if (in_ready1) exp_q1.push_back({1'b1, d});
        #1;
        in_valid1 = 1'b0; in_data1 = 8'h00; in_last1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // ---------------- out_ready randomiser ----------------
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clock) begin
        logic [10:0] e;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL out_unexpected: got sum %0d count %0d expected no result", out_sum, out_count);
            end else begin
                e = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e[7:0]));
                chk("out_count", 32'(out_count), 32'(e[10:8]));
            end
        end
    end

    always @(negedge clock) begin
        logic [8:0] e;
        if (reset_n && out_valid1 && out_ready1) begin
            if (exp_q1.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL out1_unexpected: got sum %0d expected no result", out_sum1);
            end else begin
                e = exp_q1.pop_front();
                chk("out1_sum", 32'(out_sum1), 32'(e[7:0]));
                chk("out1_count", 32'(out_count1), 32'(e[8]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int len, t;
        logic l;
        reset_n   = 1'b0;
        in_valid  = 1'b0; in_data  = 8'h00; in_last  = 1'b0; out_ready  = 1'b1;
        in_valid1 = 1'b0; in_data1 = 8'h00; in_last1 = 1'b0; out_ready1 = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_count", 32'(out_count), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_in_ready1", 32'(in_ready1), 0);
        chk("rst_phase", 32'(dbg_phase), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);
        idle(1);

        // Full frame 1,2,3,4 -> 10/4 visible for exactly one cycle
        send0(8'd1, 1'b0); send0(8'd2, 1'b0); send0(8'd3, 1'b0); send0(8'd4, 1'b0);
        chk("full_valid_latency", 32'(out_valid), 1);
        chk("full_sum", 32'(out_sum), 10);
        idle(1);
        chk("full_valid_one_cycle", 32'(out_valid), 0);

        // Short frame 5,7(last) -> 12/2; then 9,1(last) must give 10/2
        send0(8'd5, 1'b0);
        chk("accum_phase", 32'(dbg_phase), 1);
        send0(8'd7, 1'b1);
        send0(8'd9, 1'b0); send0(8'd1, 1'b1);

        // Wrap: 200,100,0,0 -> 44/4
        send0(8'd200, 1'b0); send0(8'd100, 1'b0); send0(8'd0, 1'b0); send0(8'd0, 1'b0);
        idle(2);

        // Backpressure
        out_ready = 1'b0;
        send0(8'd1, 1'b0); send0(8'd2, 1'b0); send0(8'd3, 1'b0); send0(8'd4, 1'b0);
        in_valid = 1'b1; in_data = 8'd7; in_last = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_sum_hold", 32'(out_sum), 10);
            chk("bp_out_valid_hold", 32'(out_valid), 1);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 1);
        send0(8'd7, 1'b0); send0(8'd8, 1'b1);
        idle(2);

        // NUM_INPUTS = 1: beats 3,4,5 with one-cycle gaps
        send1(8'd3); idle(1);
        send1(8'd4); idle(1);
        send1(8'd5); idle(1);
        for (int i = 0; i < 12; i++) begin
            send1(8'($urandom));
            idle($urandom_range(0, 2));
        end

        // Randomised frames with random gaps and random out_ready
        rand_ready = 1;
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 1; b <= len; b++) begin
                l = (b == len) ? ((len == 4) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                send0(8'($urandom), l);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rand_ready = 0;
        out_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0 || exp_q1.size() != 0) && t < 100) begin
            @(posedge clock);
            t++;
        end
        #1;
        chk("drain_exp_q", 32'(exp_q.size()), 0);
        chk("drain_exp_q1", 32'(exp_q1.size()), 0);
        idle(1);

        // Asynchronous reset mid-frame (previous result makes out_sum nonzero)
        send0(8'd50, 1'b1);
        idle(2);
        send0(8'd1, 1'b0); send0(8'd1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        beats_q.delete();
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_sum", 32'(out_sum), 0);
        chk("mid_rst_out_count", 32'(out_count), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_phase", 32'(dbg_phase), 0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", 32'(in_ready), 1);
        send0(8'd1, 1'b0); send0(8'd1, 1'b0); send0(8'd1, 1'b0); send0(8'd1, 1'b0);
        chk("post_rst_sum", 32'(out_sum), 4);
        chk("post_rst_count", 32'(out_count), 4);
        idle(3);
        chk("final_exp_q", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
